// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of an asynchronous PWM line, decodes a
// 0-7 brightness level and flags a stalled line as a sticky timeout.
module pwm_capture #(
    parameter int unsigned CNT_W   = 28,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high,
    output logic [2:0]       level,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StLocked
    } state_e;

    state_e           state_q;
    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_sh_q;

    // Nearest brightness level for a measured period; shorter period means brighter.
    function automatic logic [2:0] decode(input logic [CNT_W-1:0] p);
        logic [2:0] lvl;
        if      (p <= CNT_W'(450))  lvl = 3'd7;
        else if (p <= CNT_W'(700))  lvl = 3'd6;
        else if (p <= CNT_W'(1000)) lvl = 3'd5;
        else if (p <= CNT_W'(1350)) lvl = 3'd4;
        else if (p <= CNT_W'(2250)) lvl = 3'd3;
        else if (p <= CNT_W'(3500)) lvl = 3'd2;
        else if (p <= CNT_W'(7000)) lvl = 3'd1;
        else                        lvl = 3'd0;
        return lvl;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Loading 1 on a rise makes cnt equal the rise-to-rise distance at the next rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            hi_sh_q <= '0;
        end else begin
            if (rise) begin
                cnt_q <= CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fall) begin
                hi_sh_q <= cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            period  <= '0;
            high    <= '0;
            level   <= 3'd0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q <= StFirst;
                    end
                end
                StFirst, StLocked: begin
                    // A rise on the same cycle the limit is reached still counts as a period.
                    if (rise) begin
                        period  <= cnt_q;
                        high    <= hi_sh_q;
                        level   <= decode(cnt_q);
                        valid   <= 1'b1;
                        locked  <= 1'b1;
                        timeout <= 1'b0;
                        state_q <= StLocked;
                    end else if (cnt_q >= TimeoutVal) begin
                        state_q <= StIdle;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        level   <= 3'd0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives a clock-aligned PWM waveform and compares every valid strobe
// and timeout against a waveform-level reference (rise-to-rise distances, threshold table).
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 28;
    localparam int unsigned TIMEOUT = 10000;
    localparam int unsigned LAT     = 3;  // input change to registered output, aligned drive

    typedef struct packed {
        int unsigned      cyc;
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
        logic [2:0]       lvl;
    } ev_t;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [2:0]       level;
    logic             valid;
    logic             locked;
    logic             timeout;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int unsigned exp_to_q[$];
    int unsigned obs_to_q[$];
    logic        to_seen = 1'b0;

    // Reference model state, kept in terms of the driven waveform
    bit          m_armed     = 1'b0;
    bit          m_prev      = 1'b0;
    int unsigned m_last_rise = 0;
    int unsigned m_hi        = 0;

    pwm_capture #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .period (period),
        .high   (high),
        .level  (level),
        .valid  (valid),
        .locked (locked),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t o;
        if (valid) begin
            o.cyc = cyc;
            o.per = period;
            o.hi  = high;
            o.lvl = level;
            obs_q.push_back(o);
        end
        if (timeout && !to_seen) obs_to_q.push_back(cyc);
        to_seen = timeout;
    end

    function automatic logic [2:0] ref_level(input int unsigned p);
        int unsigned lim[7] = '{450, 700, 1000, 1350, 2250, 3500, 7000};
        for (int i = 0; i < 7; i++) begin
            if (p <= lim[i]) return 3'(7 - i);
        end
        return 3'd0;
    endfunction

    // One clock of input; the model predicts publishes and stalls from edge spacing.
    task automatic step(input logic v);
        ev_t e;
        @(posedge clk);
        #1;
        pwm_in = v;
        if (v && !m_prev) begin
            if (m_armed) begin
                e.cyc = cyc + LAT;
                e.per = CNT_W'(cyc - m_last_rise);
                e.hi  = CNT_W'(m_hi);
                e.lvl = ref_level(cyc - m_last_rise);
                exp_q.push_back(e);
            end
            m_armed     = 1'b1;
            m_last_rise = cyc;
        end else if (m_armed && (cyc - m_last_rise >= TIMEOUT)) begin
            m_armed = 1'b0;
            exp_to_q.push_back(cyc + LAT);
        end
        if (!v && m_prev) m_hi = cyc - m_last_rise;
        m_prev = v;
    endtask

    task automatic drive_period(input int unsigned p, input int unsigned h);
        repeat (h) step(1'b1);
        repeat (p - h) step(1'b0);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({period, high, level, valid, locked, timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_state: period=%0d high=%0d level=%0d valid=%b locked=%b timeout=%b, want all 0",
                     period, high, level, valid, locked, timeout);
        end
        rst_n = 1'b1;
        repeat (6) step(1'b0);
        n_vec++;
        if ({valid, locked, timeout} !== 3'b000 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_idle: valid=%b locked=%b timeout=%b strobes=%0d, want 0 0 0 0",
                     valid, locked, timeout, obs_q.size());
        end
    endtask

    task automatic test_generator_ref();
        ev_t e, o;
        repeat (2) drive_period(9001, 1000);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL ref_publish: no strobe, want cyc=%0d period=%0d high=%0d level=%0d",
                         e.cyc, e.per, e.hi, e.lvl);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL ref_publish: got cyc=%0d period=%0d high=%0d level=%0d, want cyc=%0d period=%0d high=%0d level=%0d",
                             o.cyc, o.per, o.hi, o.lvl, e.cyc, e.per, e.hi, e.lvl);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL ref_extra: %0d unexpected strobes, want 0", obs_q.size());
            obs_q.delete();
        end
        // 9001 lies past the 7000 threshold, so it decodes to level 0
        n_vec++;
        if (period !== 28'd9001 || high !== 28'd1000 || level !== 3'd0 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL ref_outputs: period=%0d high=%0d level=%0d locked=%b, want 9001 1000 0 1",
                     period, high, level, locked);
        end
    endtask

    task automatic test_level_sweep();
        ev_t         e, o;
        int unsigned pers[15] = '{301, 601, 801, 1201, 1501, 3001, 4001, 450, 451, 2, 3,
                                  0, 0, 0, 0};
        for (int i = 11; i < 15; i++) pers[i] = $urandom_range(1400, 8);
        for (int i = 0; i < 15; i++) drive_period(pers[i], $urandom_range(pers[i] - 1, 1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL sweep_publish: no strobe, want cyc=%0d period=%0d high=%0d level=%0d",
                         e.cyc, e.per, e.hi, e.lvl);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL sweep_publish: got cyc=%0d period=%0d high=%0d level=%0d, want cyc=%0d period=%0d high=%0d level=%0d",
                             o.cyc, o.per, o.hi, o.lvl, e.cyc, e.per, e.hi, e.lvl);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL sweep_extra: %0d unexpected strobes, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_stall_low();
        ev_t         e, o;
        int unsigned t, ot;
        repeat (2) drive_period(1201, 600);
        repeat (TIMEOUT) step(1'b0);
        n_vec++;
        if (timeout !== 1'b1 || locked !== 1'b0 || level !== 3'd0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_low_flags: timeout=%b locked=%b level=%0d valid=%b, want 1 0 0 0",
                     timeout, locked, level, valid);
        end
        n_vec++;
        if (period !== 28'd1201 || high !== 28'd600) begin
            n_err++;
            $display("FAIL stall_low_hold: period=%0d high=%0d, want 1201 600", period, high);
        end
        while (exp_to_q.size() != 0) begin
            t = exp_to_q.pop_front();
            n_vec++;
            if (obs_to_q.size() == 0) begin
                n_err++;
                $display("FAIL stall_low_timeout: no timeout seen, want cyc=%0d", t);
            end else begin
                ot = obs_to_q.pop_front();
                if (ot != t) begin
                    n_err++;
                    $display("FAIL stall_low_timeout: got cyc=%0d, want cyc=%0d", ot, t);
                end
            end
        end
        drive_period(1201, 600);
        n_vec++;
        if (timeout !== 1'b1 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL stall_low_rearm: timeout=%b locked=%b, want 1 0", timeout, locked);
        end
        drive_period(1201, 600);
        n_vec++;
        if (timeout !== 1'b0 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL stall_low_recover: timeout=%b locked=%b, want 0 1", timeout, locked);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL stall_low_publish: no strobe, want cyc=%0d period=%0d high=%0d level=%0d",
                         e.cyc, e.per, e.hi, e.lvl);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL stall_low_publish: got cyc=%0d period=%0d high=%0d level=%0d, want cyc=%0d period=%0d high=%0d level=%0d",
                             o.cyc, o.per, o.hi, o.lvl, e.cyc, e.per, e.hi, e.lvl);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0 || obs_to_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_low_extra: %0d strobes %0d timeouts unexpected, want 0 0",
                     obs_q.size(), obs_to_q.size());
            obs_q.delete();
            obs_to_q.delete();
        end
    endtask

    task automatic test_stall_high();
        ev_t         e, o;
        int unsigned t, ot;
        repeat (TIMEOUT + 8) step(1'b1);
        n_vec++;
        if (timeout !== 1'b1 || locked !== 1'b0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL stall_high_flags: timeout=%b locked=%b level=%0d, want 1 0 0",
                     timeout, locked, level);
        end
        n_vec++;
        if (period !== 28'd1201 || high !== 28'd600) begin
            n_err++;
            $display("FAIL stall_high_hold: period=%0d high=%0d, want 1201 600", period, high);
        end
        while (exp_to_q.size() != 0) begin
            t = exp_to_q.pop_front();
            n_vec++;
            if (obs_to_q.size() == 0) begin
                n_err++;
                $display("FAIL stall_high_timeout: no timeout seen, want cyc=%0d", t);
            end else begin
                ot = obs_to_q.pop_front();
                if (ot != t) begin
                    n_err++;
                    $display("FAIL stall_high_timeout: got cyc=%0d, want cyc=%0d", ot, t);
                end
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL stall_high_publish: no strobe, want cyc=%0d period=%0d high=%0d level=%0d",
                         e.cyc, e.per, e.hi, e.lvl);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL stall_high_publish: got cyc=%0d period=%0d high=%0d level=%0d, want cyc=%0d period=%0d high=%0d level=%0d",
                             o.cyc, o.per, o.hi, o.lvl, e.cyc, e.per, e.hi, e.lvl);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0 || obs_to_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_high_extra: %0d strobes %0d timeouts unexpected, want 0 0",
                     obs_q.size(), obs_to_q.size());
            obs_q.delete();
            obs_to_q.delete();
        end
        repeat (10) step(1'b0);
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        repeat (3) drive_period(301, 150);
        repeat (150) step(1'b1);
        repeat (50) step(1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        m_armed = 1'b0;
        m_hi    = 0;
        #1;
        n_vec++;
        if ({period, high, level, valid, locked, timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_clear: period=%0d high=%0d level=%0d valid=%b locked=%b timeout=%b, want all 0",
                     period, high, level, valid, locked, timeout);
        end
        repeat (3) step(1'b0);
        rst_n = 1'b1;
        drive_period(301, 150);
        n_vec++;
        if (valid !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_arm: valid=%b locked=%b after first rise, want 0 0", valid, locked);
        end
        repeat (2) drive_period(301, 150);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL reset_mid_publish: no strobe, want cyc=%0d period=%0d high=%0d level=%0d",
                         e.cyc, e.per, e.hi, e.lvl);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL reset_mid_publish: got cyc=%0d period=%0d high=%0d level=%0d, want cyc=%0d period=%0d high=%0d level=%0d",
                             o.cyc, o.per, o.hi, o.lvl, e.cyc, e.per, e.hi, e.lvl);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_mid_extra: %0d unexpected strobes, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_coincident();
        ev_t e, o;
        drive_period(TIMEOUT, $urandom_range(TIMEOUT - 1, 1));
        repeat (5) step(1'b1);
        n_vec++;
        if (period !== CNT_W'(TIMEOUT) || timeout !== 1'b0 || locked !== 1'b1 || level !== 3'd0) begin
            n_err++;
            $display("FAIL coincident_outputs: period=%0d timeout=%b locked=%b level=%0d, want %0d 0 1 0",
                     period, timeout, locked, level, TIMEOUT);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL coincident_publish: no strobe, want cyc=%0d period=%0d high=%0d level=%0d",
                         e.cyc, e.per, e.hi, e.lvl);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL coincident_publish: got cyc=%0d period=%0d high=%0d level=%0d, want cyc=%0d period=%0d high=%0d level=%0d",
                             o.cyc, o.per, o.hi, o.lvl, e.cyc, e.per, e.hi, e.lvl);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0 || obs_to_q.size() != 0 || exp_to_q.size() != 0) begin
            n_err++;
            $display("FAIL coincident_extra: %0d strobes %0d timeouts seen %0d predicted, want 0 0 0",
                     obs_q.size(), obs_to_q.size(), exp_to_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_generator_ref();
        test_level_sweep();
        test_stall_low();
        test_stall_high();
        test_reset_mid();
        test_coincident();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
